interval_scheduler: RTL and testbench

INTERVAL_SCHEDULER -- requirements
Module: interval_scheduler

---
 rtl/interval_sched_pkg.sv | 21 ++
 rtl/sync_up_counter.sv | 35 +++
 rtl/interval_scheduler.sv | 135 +++++++++++++
 tb/tb_interval_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/interval_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interval_sched_pkg
// Purpose  : Shared types and constants for the interval scheduler.
//            Holds the scheduler state enum and the default counter width.
// Revision : 1.0 - initial release
// ============================================================================
package interval_sched_pkg;

  // Default bit width of the shared interval counter and length inputs.
  localparam int unsigned c_default_width = 4;

  // Scheduler states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : interval_sched_pkg
`default_nettype wire

// File: rtl/sync_up_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_up_counter
// Purpose  : WIDTH-bit up counter with synchronous clear and count enable.
//            clr is the active-low synchronous reset; i_clear has priority
//            over i_en.
// Revision : 1.0 - initial release
// ============================================================================
module sync_up_counter
  import interval_sched_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register: reset/clear to zero, otherwise step by one when enabled.
  always_ff @(posedge clk) begin
    if (!clr || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule : sync_up_counter
`default_nettype wire

// File: rtl/interval_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : interval_scheduler
// Purpose  : Two-requester round-robin scheduler that grants a shared
//            interval counter for len_q RUN cycles followed by one DONE cycle.
//            Optional feature macro INTERVAL_SCHED_PAUSE_EN adds a pause
//            input that stalls counting in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module interval_scheduler
  import interval_sched_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
`ifdef INTERVAL_SCHED_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic [WIDTH-1:0] r_len_q;
  logic [WIDTH-1:0] w_len_nxt;
  logic             r_last;      // index of the requester served last
  logic             w_last_nxt;
  logic             w_cnt_clear;
  logic             w_cnt_en;
  logic [WIDTH-1:0] w_count;
  logic             w_win;       // arbitration winner index
  logic             w_owner;     // index of the current grant holder
  logic             w_at_end;
  logic             w_pause;

`ifdef INTERVAL_SCHED_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_win    = (req == 2'b10) || ((req == 2'b11) && !r_last);
  assign w_owner  = r_gnt[1];
  assign w_at_end = (w_count == (r_len_q - WIDTH'(1)));

  // State, grant, latched length and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_len_q <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_len_q <= w_len_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic and counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_len_nxt   = r_len_q;
    w_last_nxt  = r_last;
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_clear = 1'b1;
        w_gnt_nxt   = 2'b00;
        if (req != 2'b00) begin
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_len_nxt   = w_win ? len1 : len0;
          w_state_nxt = (w_len_nxt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!req[w_owner]) begin
          // Abort: release without a done pulse, but count as served.
          w_state_nxt = IDLE;
          w_gnt_nxt   = 2'b00;
          w_cnt_clear = 1'b1;
          w_last_nxt  = w_owner;
        end else if (w_pause) begin
          w_state_nxt = RUN;
        end else if (w_at_end) begin
          // Counter holds its final value through DONE.
          w_state_nxt = DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
        w_cnt_clear = 1'b1;
        w_last_nxt  = w_owner;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
        w_cnt_clear = 1'b1;
      end
    endcase
  end

  sync_up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk     (clk),
    .clr     (clr),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

  assign gnt   = r_gnt;
  assign done  = (r_state == DONE) ? r_gnt : 2'b00;
  assign busy  = (r_state != IDLE);
  assign count = w_count;

endmodule : interval_scheduler
`default_nettype wire

// File: tb/tb_interval_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_interval_scheduler
// Purpose  : Self-checking bench for interval_scheduler: directed scenarios
//            plus randomized traffic compared against a behavioural model.
//            Honors INTERVAL_SCHED_PAUSE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interval_scheduler;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
`ifdef INTERVAL_SCHED_PAUSE_EN
  logic       pause;
`endif
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] count;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner (-1 when idle), ticks elapsed, latched length, last served.
  int m_own  = -1;
  int m_el   = 0;
  int m_len  = 0;
  int m_last = 0;

  interval_scheduler #(.WIDTH(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
`ifdef INTERVAL_SCHED_PAUSE_EN
    .pause (pause),
`endif
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled at it.
  task automatic model_step(input logic [1:0] r, input int l0, input int l1,
                            input logic c, input logic p);
    int w;
    if (!c) begin
      m_own  = -1;
      m_last = 0;
    end else if (m_own < 0) begin
      if (r != 2'b00) begin
        if (r == 2'b01)      w = 0;
        else if (r == 2'b10) w = 1;
        else                 w = (m_last == 0) ? 1 : 0;
        m_own = w;
        m_len = (w == 1) ? l1 : l0;
        m_el  = 0;
      end
    end else if (m_el == m_len) begin
      m_last = m_own;
      m_own  = -1;
    end else if (!r[m_own]) begin
      m_last = m_own;
      m_own  = -1;
    end else if (!p) begin
      m_el++;
    end
  endtask

  task automatic check_outputs();
    int e_gnt, e_done, e_busy, e_cnt;
    if (m_own < 0) begin
      e_gnt = 0; e_done = 0; e_busy = 0; e_cnt = 0;
    end else begin
      e_gnt  = 1 << m_own;
      e_busy = 1;
      if (m_el < m_len) begin
        e_done = 0;
        e_cnt  = m_el;
      end else begin
        e_done = 1 << m_own;
        e_cnt  = (m_len == 0) ? 0 : m_len - 1;
      end
    end
    chk("gnt",   32'(gnt),   32'(e_gnt));
    chk("done",  32'(done),  32'(e_done));
    chk("busy",  32'(busy),  32'(e_busy));
    chk("count", 32'(count), 32'(e_cnt));
  endtask

  // Apply one cycle of inputs, advance the model, and compare.
  task automatic cyc(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                     input logic c, input logic p);
    logic p_eff;
    @(negedge clk);
    req  = r;
    len0 = l0;
    len1 = l1;
    clr  = c;
`ifdef INTERVAL_SCHED_PAUSE_EN
    pause = p;
    p_eff = p;
`else
    p_eff = 1'b0;
`endif
    @(posedge clk);
    model_step(r, int'(l0), int'(l1), c, p_eff);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [1:0] r;
    logic       c;
    logic       p;
    req  = 2'b00;
    len0 = 4'd0;
    len1 = 4'd0;
    clr  = 1'b0;
`ifdef INTERVAL_SCHED_PAUSE_EN
    pause = 1'b0;
`endif

    // Reset.
    repeat (2) cyc(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);

    // Single requester, len0=3.
    repeat (5) cyc(2'b01, 4'd3, 4'd0, 1'b1, 1'b0);
    repeat (3) cyc(2'b00, 4'd3, 4'd0, 1'b1, 1'b0);

    // Both requesting, round-robin alternation (after a fresh reset).
    cyc(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (14) cyc(2'b11, 4'd2, 4'd2, 1'b1, 1'b0);
    repeat (2) cyc(2'b00, 4'd2, 4'd2, 1'b1, 1'b0);

    // Zero-length interval for requester 1.
    cyc(2'b10, 4'd0, 4'd0, 1'b1, 1'b0);
    repeat (3) cyc(2'b00, 4'd0, 4'd0, 1'b1, 1'b0);

    // Abort at count=2 of len0=5; len changes during RUN must be ignored.
    cyc(2'b01, 4'd5, 4'd0, 1'b1, 1'b0);
    cyc(2'b01, 4'd9, 4'd7, 1'b1, 1'b0);
    cyc(2'b01, 4'd1, 4'd7, 1'b1, 1'b0);
    repeat (2) cyc(2'b00, 4'd5, 4'd0, 1'b1, 1'b0);

    // Reset at count=7 of a len=12 interval.
    repeat (8) cyc(2'b01, 4'd12, 4'd0, 1'b1, 1'b0);
    cyc(2'b01, 4'd12, 4'd0, 1'b0, 1'b0);
    repeat (2) cyc(2'b00, 4'd12, 4'd0, 1'b1, 1'b0);

    // Maximum length, no wrap.
    repeat (18) cyc(2'b10, 4'd0, 4'd15, 1'b1, 1'b0);
    repeat (2) cyc(2'b00, 4'd0, 4'd15, 1'b1, 1'b0);

`ifdef INTERVAL_SCHED_PAUSE_EN
    // Pause for three cycles at count=1 of len0=4.
    repeat (2) cyc(2'b01, 4'd4, 4'd0, 1'b1, 1'b0);
    repeat (3) cyc(2'b01, 4'd4, 4'd0, 1'b1, 1'b1);
    repeat (5) cyc(2'b01, 4'd4, 4'd0, 1'b1, 1'b0);
    repeat (2) cyc(2'b00, 4'd4, 4'd0, 1'b1, 1'b0);
`endif

    // Randomized traffic: sticky requests with occasional toggles.
    r = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) r[0] = ~r[0];
      if ($urandom_range(0, 15) == 0) r[1] = ~r[1];
      c = ($urandom_range(0, 99) != 0);
      p = ($urandom_range(0, 3) == 0);
      cyc(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), c, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_interval_scheduler
`default_nettype wire
